// File: rtl/digital_logic_pkg.sv
// Shared constants and state encoding for the code-byte decoder.
package digital_logic_pkg;

  localparam logic [7:0] CODE_NONE  = 8'hF0;
  localparam int         MAX_IDX    = 14;
  localparam int         ENABLE_BIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus edge flop; rise pulses for one cycle per low-to-high transition.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/tt_um_decoder_tt10_digitallogic.sv
// Strobed code-byte decoder: emits the 16-bit one-hot word as a low then high byte, each held HOLD cycles.
import digital_logic_pkg::*;

module tt_um_decoder_tt10_digitallogic #(
  parameter int HOLD = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam logic [7:0] HOLD_CNT = 8'(HOLD);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] w_q, w_d, dec_w;
  logic        err_q, err_d, dec_err;
  logic        drop_q, drop_d;
  logic [7:0]  uo_q, uo_d;
  logic        busy_q, busy_d, half_q, half_d, vld_q, vld_d;
  logic        rise;
  logic        unused_in;

  assign unused_in = &{1'b0, ena, uio_in[7:1]};

  sync_edge u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (uio_in[0]),
    .rise     (rise)
  );

  always_comb begin
    dec_w   = 16'h0000;
    dec_err = 1'b1;
    if (ui_in <= 8'(MAX_IDX)) begin
      dec_w   = (16'd1 << ENABLE_BIT) | (16'd1 << ui_in[3:0]);
      dec_err = 1'b0;
    end else if (ui_in == CODE_NONE) begin
      dec_w   = 16'd1 << ENABLE_BIT;
      dec_err = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    err_d   = err_q;
    drop_d  = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          w_d     = dec_w;
          err_d   = dec_err;
          drop_d  = 1'b0;
          cnt_d   = HOLD_CNT;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (rise) drop_d = 1'b1;
        if (cnt_q <= 8'd1) begin
          cnt_d   = HOLD_CNT;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HIGH: begin
        // An edge landing on the final HIGH cycle is gone by IDLE, so it is dropped here.
        if (rise) drop_d = 1'b1;
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    uo_d   = 8'h00;
    busy_d = 1'b0;
    half_d = 1'b0;
    vld_d  = 1'b0;
    case (state_d)
      ST_LOW: begin
        uo_d   = w_d[7:0];
        busy_d = 1'b1;
        vld_d  = 1'b1;
      end
      ST_HIGH: begin
        uo_d   = w_d[15:8];
        busy_d = 1'b1;
        half_d = 1'b1;
        vld_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      w_q     <= 16'h0000;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      uo_q    <= 8'h00;
      busy_q  <= 1'b0;
      half_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      uo_q    <= uo_d;
      busy_q  <= busy_d;
      half_q  <= half_d;
      vld_q   <= vld_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {2'b00, drop_q, err_q, vld_q, half_q, busy_q, 1'b0};
  assign uio_oe  = 8'b0011_1110;

endmodule
